// File: rtl/bus_responder.sv
// 6502 bus responder: on-chip RAM, a 16-bit reload timer at 0xD000-0xD005, 0xFF for unmapped space.
// Ready pulses 1+W cycles after the request (W = per-region wait count); requests are held until ready, ignored in ACK.
module bus_responder #(
   parameter int RAM_AW   = 11,
   parameter int RAM_WAIT = 0,
   parameter int IO_WAIT  = 1
) (
   input  logic        ph2,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  cpu_wdata,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [7:0]  data_in,
   output logic        ready,
   output logic        irq
);
   localparam int          RAM_SIZE = 1 << RAM_AW;
   localparam logic [16:0] RAM_TOP  = 17'(RAM_SIZE);
   localparam logic [7:0]  RAM_W8   = 8'(RAM_WAIT);
   localparam logic [7:0]  IO_W8    = 8'(IO_WAIT);

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t      state;
   logic [15:0] lat_addr;
   logic        lat_we;
   logic [7:0]  lat_wdata;
   logic [7:0]  wcnt;

   logic [7:0]  mem [RAM_SIZE];
   logic [15:0] rld;
   logic [15:0] cnt;
   logic        en, ie, pend;

   logic              req;
   logic [15:0]       acc_addr;
   logic              acc_we;
   logic [7:0]        acc_wdata;
   logic              is_ram, is_io;
   logic [7:0]        wait_cnt;
   logic              commit, wr_commit, rd_commit;
   logic [7:0]        io_rd, rd_val;
   logic              io_wr, en_rise, stat_clr, tick_zero;
   logic [RAM_AW-1:0] ram_idx;

   // A zero-wait access commits on the request edge itself, so decode from live inputs while IDLE.
   always_comb begin
      req       = mem_read | mem_write;
      acc_addr  = (state == IDLE) ? address   : lat_addr;
      acc_we    = (state == IDLE) ? mem_write : lat_we;
      acc_wdata = (state == IDLE) ? cpu_wdata : lat_wdata;
      ram_idx   = acc_addr[RAM_AW-1:0];
      is_ram    = ({1'b0, acc_addr} < RAM_TOP);
      is_io     = (acc_addr[15:3] == 13'h1A00) && (acc_addr[2:0] <= 3'd5);
      wait_cnt  = is_ram ? RAM_W8 : IO_W8;
      commit    = ((state == IDLE) && req && (wait_cnt == 8'd0)) ||
                  ((state == BUSY) && (wcnt == 8'd1));
      wr_commit = commit & acc_we;
      rd_commit = commit & ~acc_we;

      case (acc_addr[2:0])
         3'd0:    io_rd = rld[7:0];
         3'd1:    io_rd = rld[15:8];
         3'd2:    io_rd = {6'b0, ie, en};
         3'd3:    io_rd = {7'b0, pend};
         3'd4:    io_rd = cnt[7:0];
         3'd5:    io_rd = cnt[15:8];
         default: io_rd = 8'hFF;
      endcase
      rd_val = is_ram ? mem[ram_idx] : (is_io ? io_rd : 8'hFF);

      io_wr     = wr_commit & is_io;
      en_rise   = io_wr && (acc_addr[2:0] == 3'd2) && acc_wdata[0] && !en;
      stat_clr  = io_wr && (acc_addr[2:0] == 3'd3) && acc_wdata[0];
      tick_zero = en && !en_rise && (cnt == 16'd0);
   end

   always_ff @(posedge ph2) begin
      if (reset) begin
         state     <= IDLE;
         ready     <= 1'b0;
         data_in   <= 8'h00;
         lat_addr  <= 16'h0000;
         lat_we    <= 1'b0;
         lat_wdata <= 8'h00;
         wcnt      <= 8'd0;
      end else begin
         ready <= 1'b0;
         case (state)
            IDLE: if (req) begin
               lat_addr  <= address;
               lat_we    <= mem_write;
               lat_wdata <= cpu_wdata;
               wcnt      <= wait_cnt;
               if (wait_cnt == 8'd0) begin
                  state <= ACK;
                  ready <= 1'b1;
               end else begin
                  state <= BUSY;
               end
            end
            BUSY: begin
               wcnt <= wcnt - 8'd1;
               if (wcnt == 8'd1) begin
                  state <= ACK;
                  ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         if (rd_commit) data_in <= rd_val;
      end
   end

   // RAM contents survive reset; a write cut short by reset never reaches the array.
   always_ff @(posedge ph2) begin
      if (!reset && wr_commit && is_ram) mem[ram_idx] <= acc_wdata;
   end

   always_ff @(posedge ph2) begin
      if (reset) begin
         rld  <= 16'h0000;
         cnt  <= 16'h0000;
         en   <= 1'b0;
         ie   <= 1'b0;
         pend <= 1'b0;
      end else begin
         if (io_wr && acc_addr[2:0] == 3'd0) rld[7:0]  <= acc_wdata;
         if (io_wr && acc_addr[2:0] == 3'd1) rld[15:8] <= acc_wdata;
         if (io_wr && acc_addr[2:0] == 3'd2) begin
            en <= acc_wdata[0];
            ie <= acc_wdata[1];
         end
         if (en_rise)        cnt <= rld;
         else if (tick_zero) cnt <= rld;
         else if (en)        cnt <= cnt - 16'd1;
         // A new expiry outranks a same-edge clear.
         pend <= tick_zero | (pend & ~stat_clr);
      end
   end

   assign irq = pend & ie;
endmodule
